// File: rtl/tc_pkg.sv
// Shared types and constants for the tensor-core MAC datapath.
// Default widths, accumulator FSM states and signed bounds.
package tc_pkg;

  localparam int DW_DATA_D = 8;
  localparam int DW_ACC_D  = 32;
  localparam int DW_K_D    = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [DW_ACC_D-1:0] ACC_MAX =
    {1'b0, {(DW_ACC_D-1){1'b1}}};
  localparam logic [DW_ACC_D-1:0] ACC_MIN =
    {1'b1, {(DW_ACC_D-1){1'b0}}};

endpackage

// File: rtl/psum_accumulator_acc_sat_add.sv
// Sign-extending accumulate adder with overflow detect.
// Clamps to signed bounds when SAT is set, else wraps.
module acc_sat_add #(
  parameter int DW_DATA = 8,
  parameter int DW_ACC  = 32,
  parameter bit SAT     = 1'b1
) (
  input  logic [DW_ACC-1:0]  acc,
  input  logic [DW_DATA-1:0] data,
  output logic [DW_ACC-1:0]  sum,
  output logic               ovf
);

  localparam logic [DW_ACC-1:0] MAXV =
    {1'b0, {(DW_ACC-1){1'b1}}};
  localparam logic [DW_ACC-1:0] MINV =
    {1'b1, {(DW_ACC-1){1'b0}}};

  logic [DW_ACC-1:0] ext;
  logic [DW_ACC-1:0] raw;

  // add, flag same-sign operands giving a flipped sign, clamp
  always_comb begin
    ext = {{(DW_ACC-DW_DATA){data[DW_DATA-1]}}, data};
    raw = acc + ext;
    ovf = (acc[DW_ACC-1] == ext[DW_ACC-1]) &&
          (raw[DW_ACC-1] != acc[DW_ACC-1]);
    sum = raw;
    if (SAT && ovf) begin
      sum = acc[DW_ACC-1] ? MINV : MAXV;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// K-group partial-sum accumulator behind the adder tree.
// One-entry output register with valid/ready handshake.
module psum_accumulator
  import tc_pkg::*;
#(
  parameter int DW_DATA = DW_DATA_D,
  parameter int DW_ACC  = DW_ACC_D,
  parameter int DW_K    = DW_K_D,
  parameter bit SAT     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [DW_K-1:0]    cfg_k_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW_DATA-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW_ACC-1:0]  out_data,
  output logic               sat_flag,
  output logic               busy
);

  state_t            state;
  state_t            state_nx;
  logic [DW_ACC-1:0] acc;
  logic [DW_K-1:0]   cnt;
  logic [DW_K-1:0]   k_lat;
  logic [DW_K-1:0]   k_cfg;
  logic              grp_ovf;
  logic              take;
  logic              hs;
  logic              last;
  logic [DW_ACC-1:0] sum;
  logic              ovf;

  assign in_ready = !clr && (!out_valid || out_ready);
  assign take     = in_valid && in_ready;
  assign hs       = out_valid && out_ready;
  assign k_cfg    = (cfg_k_len == '0) ? DW_K'(1) : cfg_k_len;
  assign busy     = (state == ACCUM);

  acc_sat_add #(
    .DW_DATA (DW_DATA),
    .DW_ACC  (DW_ACC),
    .SAT     (SAT)
  ) u_add (
    .acc  (acc),
    .data (in_data),
    .sum  (sum),
    .ovf  (ovf)
  );

  // next state and last-beat decode
  always_comb begin
    state_nx = state;
    last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (take) begin
          last = (k_cfg == DW_K'(1));
          if (!last) state_nx = ACCUM;
        end
      end
      ACCUM: begin
        if (take && (cnt == k_lat - DW_K'(1))) begin
          last     = 1'b1;
          state_nx = IDLE;
        end
      end
    endcase
    if (clr) state_nx = IDLE;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // accumulator, beat counter, latched group length, overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      k_lat   <= '0;
      grp_ovf <= 1'b0;
    end else if (clr) begin
      acc     <= '0;
      cnt     <= '0;
      grp_ovf <= 1'b0;
    end else if (take) begin
      if (state == IDLE) k_lat <= k_cfg;
      if (last) begin
        acc     <= '0;
        cnt     <= '0;
        grp_ovf <= 1'b0;
      end else begin
        acc     <= sum;
        cnt     <= cnt + DW_K'(1);
        grp_ovf <= grp_ovf | ovf;
      end
    end
  end

  // output register: load on last beat, drop on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else if (take && last) begin
      out_valid <= 1'b1;
      out_data  <= sum;
      sat_flag  <= grp_ovf | ovf;
    end else if (hs) begin
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator.
// Three instances (32b sat, 10b sat, 10b wrap) share stimulus.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  cfg_k_len = 8'd0;
  logic [7:0]  in_data = 8'd0;

  logic        rdy [3];
  logic        ov  [3];
  logic        sf  [3];
  logic        bz  [3];
  logic [31:0] od0;
  logic [9:0]  od1;
  logic [9:0]  od2;

  int checks = 0;
  int errors = 0;

  // model state
  int     grp[$];
  int     m_k = 1;
  bit     m_valid = 1'b0;
  longint m_data [3] = '{0, 0, 0};
  bit     m_flag [3] = '{0, 0, 0};
  int     wd     [3] = '{32, 10, 10};
  bit     sm     [3] = '{1'b1, 1'b1, 1'b0};

  bit     e_rdy;
  bit     e_hs;
  bit     e_last;
  bit     e_f;

  always #5 clk = ~clk;

  psum_accumulator #(
    .DW_DATA(8), .DW_ACC(32), .DW_K(8), .SAT(1'b1)
  ) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .cfg_k_len(cfg_k_len),
    .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0),
    .sat_flag(sf[0]), .busy(bz[0])
  );

  psum_accumulator #(
    .DW_DATA(8), .DW_ACC(10), .DW_K(8), .SAT(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .cfg_k_len(cfg_k_len),
    .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1),
    .sat_flag(sf[1]), .busy(bz[1])
  );

  psum_accumulator #(
    .DW_DATA(8), .DW_ACC(10), .DW_K(8), .SAT(1'b0)
  ) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .cfg_k_len(cfg_k_len),
    .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od2),
    .sat_flag(sf[2]), .busy(bz[2])
  );

  task automatic chk(string name, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  // group result: running sum with per-step clamp or wrap
  function automatic longint fold(input int q[$], input int w,
                                  input bit s, output bit f);
    longint a;
    longint mx;
    longint mn;
    a  = 0;
    f  = 1'b0;
    mx = (64'sd1 <<< (w - 1)) - 1;
    mn = -(64'sd1 <<< (w - 1));
    foreach (q[j]) begin
      a = a + q[j];
      if (a > mx) begin
        f = 1'b1;
        a = s ? mx : a - (64'sd1 <<< w);
      end else if (a < mn) begin
        f = 1'b1;
        a = s ? mn : a + (64'sd1 <<< w);
      end
    end
    return a;
  endfunction

  // reference model: beats grouped into queue, result on group close
  always @(posedge clk) begin
    if (!rst) begin
      e_rdy  = !clr && (!m_valid || out_ready);
      e_hs   = m_valid && out_ready;
      e_last = 1'b0;
      if (in_valid && e_rdy) begin
        if (grp.size() == 0)
          m_k = (cfg_k_len == 0) ? 1 : int'(cfg_k_len);
        grp.push_back(int'($signed(in_data)));
        if (grp.size() == m_k) e_last = 1'b1;
      end
      if (clr) grp.delete();
      if (e_last) begin
        for (int i = 0; i < 3; i++) begin
          m_data[i] = fold(grp, wd[i], sm[i], e_f);
          m_flag[i] = e_f;
        end
        m_valid = 1'b1;
        grp.delete();
      end else if (e_hs) begin
        m_valid = 1'b0;
        for (int i = 0; i < 3; i++) m_flag[i] = 1'b0;
      end
    end
  end

  always @(posedge rst) begin
    grp.delete();
    m_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_data[i] = 0;
      m_flag[i] = 1'b0;
    end
  end

  // compare process
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("in_ready%0d", i), longint'(rdy[i]),
            longint'(!clr && (!m_valid || out_ready)));
        chk($sformatf("out_valid%0d", i), longint'(ov[i]),
            longint'(m_valid));
        chk($sformatf("busy%0d", i), longint'(bz[i]),
            longint'(grp.size() > 0));
        chk($sformatf("sat_flag%0d", i), longint'(sf[i]),
            longint'(m_flag[i]));
      end
      if (m_valid) begin
        chk("out_data0", longint'(od0), m_data[0] & 64'hFFFF_FFFF);
        chk("out_data1", longint'(od1), m_data[1] & 64'h3FF);
        chk("out_data2", longint'(od2), m_data[2] & 64'h3FF);
      end
    end
  end

  task automatic step(input bit v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'd0;
  endtask

  initial begin
    #2;
    chk("rst_out_valid", longint'(ov[0]), 0);
    chk("rst_out_data", longint'(od0), 0);
    chk("rst_busy", longint'(bz[0]), 0);
    chk("rst_sat_flag", longint'(sf[0]), 0);
    chk("rst_in_ready", longint'(rdy[0]), 1);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: k=4 -> 110
    cfg_k_len = 8'd4;
    step(1, 8'h1C); step(1, 8'h1B); step(1, 8'h1C); step(1, 8'h1B);
    chk("t1_valid", longint'(ov[0]), 1);
    chk("t1_data", longint'(od0), 110);
    chk("t1_flag", longint'(sf[0]), 0);
    chk("t1_model", m_data[0], 110);

    // 2: k=3 of -128 -> -384
    cfg_k_len = 8'd3;
    step(1, 8'h80); step(1, 8'h80); step(1, 8'h80);
    chk("t2_data", longint'(od0), 64'hFFFF_FE80);

    // 3: stall then back-to-back
    step(0, 8'h00);
    out_ready = 1'b0;
    cfg_k_len = 8'd2;
    step(1, 8'd7); step(1, 8'd5);
    chk("t3_data", longint'(od0), 12);
    in_valid = 1'b1;
    in_data  = 8'd1;
    #1;
    chk("t3_stall_rdy", longint'(rdy[0]), 0);
    @(posedge clk);
    #1;
    chk("t3_hold_valid", longint'(ov[0]), 1);
    chk("t3_hold_data", longint'(od0), 12);
    out_ready = 1'b1;
    #1;
    chk("t3_rdy_up", longint'(rdy[0]), 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    chk("t3_next_data", longint'(od0), 2);
    chk("t3_next_valid", longint'(ov[0]), 1);

    // 4: saturation vs wrap on 10-bit
    cfg_k_len = 8'd5;
    repeat (5) step(1, 8'h7F);
    chk("t4_sat_data", longint'(od1), 511);
    chk("t4_sat_flag", longint'(sf[1]), 1);
    chk("t4_wrap_data", longint'(od2), 64'h27B);
    chk("t4_wrap_flag", longint'(sf[2]), 1);
    chk("t4_wide_data", longint'(od0), 635);

    // 5: k=0 acts as 1, k change mid-group ignored
    cfg_k_len = 8'd0;
    step(1, 8'hFF);
    chk("t5_k0_a", longint'(od0), 64'hFFFF_FFFF);
    step(1, 8'h05);
    chk("t5_k0_b", longint'(od0), 5);
    cfg_k_len = 8'd4;
    step(1, 8'd1);
    cfg_k_len = 8'd2;
    step(1, 8'd1); step(1, 8'd1);
    chk("t5_kchg_valid", longint'(ov[0]), 0);
    chk("t5_kchg_busy", longint'(bz[0]), 1);
    step(1, 8'd1);
    chk("t5_kchg_data", longint'(od0), 4);

    // 6: clr flush then full group
    cfg_k_len = 8'd4;
    step(1, 8'd1); step(1, 8'd2);
    clr = 1'b1;
    step(0, 8'd0);
    clr = 1'b0;
    chk("t6_clr_busy", longint'(bz[0]), 0);
    repeat (4) step(1, 8'd3);
    chk("t6_clr_data", longint'(od0), 12);

    // async reset mid-group
    step(0, 8'd0);
    step(1, 8'd1); step(1, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", longint'(bz[0]), 0);
    chk("t6_rst_valid", longint'(ov[0]), 0);
    chk("t6_rst_data", longint'(od0), 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // async reset while holding
    out_ready = 1'b0;
    cfg_k_len = 8'd1;
    step(1, 8'd9);
    chk("t6_hold_valid", longint'(ov[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rsth_valid", longint'(ov[0]), 0);
    chk("t6_rsth_data", longint'(od0), 0);
    chk("t6_rsth_busy", longint'(bz[0]), 0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cfg_k_len = ($urandom_range(0, 9) == 0) ?
                  8'($urandom_range(0, 20)) : 8'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 9) < 7);
      clr       = ($urandom_range(0, 59) == 0);
      step(($urandom_range(0, 9) < 7), 8'($urandom));
    end
    clr = 1'b0;
    out_ready = 1'b1;
    repeat (3) step(0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
Downstream stage of adder_tree in the sparse tensor core MAC datapath. Consumes one signed reduced partial sum per cycle from the adder tree and accumulates cfg_k_len consecutive beats (one K-reduction group) into a wide accumulator. It then presents the finished dot-product result through a one-entry output register with a valid/ready handshake. It also optionally saturates and flags overflow.

Parameters:
DW_DATA, 8, width of incoming adder-tree sum (two's complement, signed)
DW_ACC, 32, accumulator/result width (signed), must be > DW_DATA
DW_K, 8, width of cfg_k_len
SAT, 1, 1 = saturate to signed DW_ACC bounds, 0 = wrap modulo 2^DW_ACC

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  sync flush of the partial group (acc, count), priority over in_valid
cfg_k_len  in  DW_K  beats per group; sampled on the first accepted beat of each group; 0 treated as 1
in_valid  in  1  in_data valid
in_ready  out  1  beat accepted when in_valid & in_ready
in_data  in  DW_DATA  signed sum from adder_tree
out_valid  out  1  result valid, held until accepted
out_ready  in  1  consumer ready
out_data  out  DW_ACC  signed group result
sat_flag  out  1  sticky: any saturation/overflow in the current held result
busy  out  1  group in progress (state ACCUM)

Behaviour:
- Reset (async, rst=1): acc=0, cnt=0, k_lat=0, state=IDLE, out_valid=0, out_data=0, sat_flag=0. Effective immediately and independent of clk. A group in flight is discarded.
- State IDLE (cnt==0):
  - First accepted beat latches k_lat = max(cfg_k_len,1).
  - If k_lat==1, the beat is also the last beat. Otherwise acc = sext(in_data), cnt=1, and the state goes to ACCUM.
- State ACCUM:
  - Each accepted beat computes acc = acc + sext(in_data) and cnt+1.
  - The beat where cnt==k_lat-1 is the last beat.
  - cfg_k_len changes mid-group are ignored.
- Last beat handling:
  - The next cycle has out_data = acc + sext(in_data), with saturation per SAT, and out_valid=1.
  - In that same cycle acc=0, cnt=0, and the state returns to IDLE.
  - Latency is 1 cycle from last-beat acceptance to out_valid.
- Arithmetic:
  - in_data is sign-extended to DW_ACC.
  - SAT=1: on signed overflow, the sum clamps to 2^(DW_ACC-1)-1 or -2^(DW_ACC-1), and the group's sat_flag is set.
  - SAT=0: the sum wraps and sat_flag is still set on overflow.
  - A sticky group overflow bit carries to the output. sat_flag is loaded with out_data and cleared on handshake unless a new result loads in the same cycle.
- Handshake:
  - in_ready = !clr & (!out_valid | out_ready). It is combinational from out_ready and the output register state.
  - This holds for all beats, so the accumulator never runs ahead of an unaccepted result.
  - out_valid/out_data/sat_flag are stable while out_valid & !out_ready.
  - out_valid deasserts on handshake unless the last beat is accepted in the same cycle. In that case out_valid stays 1 with the new data, giving back-to-back groups at full rate.
- clr:
  - Zeroes acc, cnt and the group overflow bit, and returns the state to IDLE.
  - A held output register is untouched.
  - in_ready=0 during clr, so no beat is consumed.
- busy = (state==ACCUM).

Decomposition:
- The shared package (tc_pkg) holds DW_DATA/DW_ACC defaults, the state enum {IDLE, ACCUM}, and the signed min/max constants for DW_ACC.
- One combinational sub-module, acc_sat_add: sign-extend, add, overflow detect, SAT-selected clamp/wrap. Outputs sum and ovf.
- Counter, FSM and output register stay in psum_accumulator.

Test Plan:
1. k_len=4, out_ready=1, beats 0x1C,0x1B,0x1C,0x1B on consecutive cycles -> out_valid one cycle after 4th beat, out_data=110, sat_flag=0, in_ready stays 1.
2. k_len=3, beats 0x80 x3 -> out_data=0xFFFFFE80 (-384).
3. Back-to-back:
   - k_len=2, out_ready=0 after first result (7+5=12) -> in_ready=0, out_data held 12.
   - Raise out_ready -> in_ready=1 that cycle.
   - Next group 1+1 -> 2. No beat lost, none duplicated.
4. Saturation, DW_ACC=10, k_len=5, beats 0x7F x5:
   - SAT=1 -> out_data=511, sat_flag=1.
   - SAT=0 -> out_data=-389 (0x27B), sat_flag=1.
5. k_len boundaries:
   - k_len=0 with beats 0xFF,0x05 -> two results, -1 then 5, each 1 cycle after its beat.
   - cfg_k_len changed 4->2 after the first beat of a group -> group still takes 4 beats.
6. Flush and reset:
   - clr after 2 of 4 beats (1,2) -> busy=0; the following 4 beats of 3 give 12.
   - rst asserted mid-group and mid-hold -> out_valid=0, out_data=0, busy=0 immediately without a clock edge.
